alu_cmd_issuer: RTL and testbench

Initiator-side driver for the single-cycle 8-bit ALU (start/op/A/B in, done/result out). It accepts commands on an upstream valid/ready interface and pulses the ALU start for exactly one cycle. It then waits for done with a timeout and returns the 16-bit result on a downstream valid/ready response interface. It sits between the test/stimulus fabric and the ALU, and also keeps a saturating completion count.

---
 rtl/alu_cmd_pkg.sv | 22 ++
 rtl/alu_cmd_issuer.sv | 100 ++++++++++
 tb/tb_alu_cmd_issuer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - opcode, status and state encodings for the ALU command issuer
package alu_cmd_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - drives one ALU command at a time, waits for done with timeout, returns the result
module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic             alu_start,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic             alu_done,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [2:0]       rsp_op,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [7:0] tmo_cnt;

  // cmd_ready is forced low while reset is held, even before the first reset edge
  assign cmd_ready = reset_n && (state == S_IDLE);
  assign alu_start = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= 8'd0;
      alu_op     <= 3'b000;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_result <= 16'h0000;
      rsp_op     <= 3'b000;
      rsp_status <= ST_OK;
      done_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_op <= cmd_op;
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            if (is_legal_op(cmd_op)) begin
              state <= S_ISSUE;
            end else begin
              state      <= S_RESP;
              rsp_result <= 16'h0000;
              rsp_op     <= cmd_op;
              rsp_status <= ST_ILLEGAL;
            end
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          tmo_cnt <= 8'd0;
        end
        S_WAIT: begin
          // the cycle that reaches TIMEOUT_CYCLES waiting cycles gives up
          if (alu_done) begin
            state      <= S_RESP;
            rsp_result <= alu_result;
            rsp_op     <= alu_op;
            rsp_status <= ST_OK;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= S_RESP;
            rsp_result <= 16'h0000;
            rsp_op     <= alu_op;
            rsp_status <= ST_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
            if (rsp_status == ST_OK && done_cnt != CNT_MAX)
              done_cnt <= done_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed table-driven bench for alu_cmd_issuer
module tb_alu_cmd_issuer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_status;
  logic [15:0] done_cnt;

  logic        model_done = 1'b0;
  logic [15:0] model_res  = 16'h0;
  logic        alu_hang   = 1'b0;
  logic        late_done  = 1'b0;
  int          start_cnt  = 0;
  int          checks     = 0;
  int          errors     = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_status(rsp_status), .done_cnt(done_cnt)
  );

  // Single-cycle ALU: done and result registered one edge after start
  always @(posedge clk) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    model_done <= alu_start && !alu_hang;
    case (alu_op)
      3'b001:  model_res <= 16'(alu_a) + 16'(alu_b);
      3'b010:  model_res <= {8'h00, alu_a & alu_b};
      3'b011:  model_res <= {8'h00, alu_a ^ alu_b};
      default: model_res <= 16'h0;
    endcase
  end
  assign alu_done   = model_done | late_done;
  assign alu_result = model_res;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge right after acceptance; returns cycles until rsp_valid
  task automatic wait_rsp(output int lat, output int ready_hi);
    lat = 0;
    ready_hi = 0;
    while (!rsp_valid && lat < 100) begin
      if (cmd_ready) ready_hi++;
      @(negedge clk);
      lat++;
    end
    if (cmd_ready) ready_hi++;
    if (lat >= 100) chk("rsp_timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    int lat, rhi, s0, exp_cnt;

    vecs[0] = '{op: 3'b001, a: 8'hFF, b: 8'h01, res: 16'h0100, st: 2'b00, lat: 2};
    vecs[1] = '{op: 3'b010, a: 8'hF0, b: 8'h3C, res: 16'h0030, st: 2'b00, lat: 2};
    vecs[2] = '{op: 3'b011, a: 8'hAA, b: 8'h55, res: 16'h00FF, st: 2'b00, lat: 2};
    vecs[3] = '{op: 3'b000, a: 8'h12, b: 8'h34, res: 16'h0000, st: 2'b01, lat: 0};
    vecs[4] = '{op: 3'b101, a: 8'h56, b: 8'h78, res: 16'h0000, st: 2'b01, lat: 0};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_a = 8'h0; cmd_b = 8'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_alu_start", 32'(alu_start), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_done_cnt", 32'(done_cnt), 32'd0);
    chk("reset_rsp_result", 32'(rsp_result), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat, rhi);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
      chk($sformatf("v%0d_status", i), 32'(rsp_status), 32'(vecs[i].st));
      chk($sformatf("v%0d_rsp_op", i), 32'(rsp_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_ready_low", i), 32'(rhi), 32'd0);
      chk($sformatf("v%0d_starts", i), 32'(start_cnt - s0), (vecs[i].st == 2'b00) ? 32'd1 : 32'd0);
      if (vecs[i].st == 2'b00) exp_cnt++;
      @(negedge clk);
      chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'(exp_cnt));
      chk($sformatf("v%0d_valid_drop", i), 32'(rsp_valid), 32'd0);
    end

    // Timeout: ALU never answers; a late done must not disturb the pending response
    alu_hang = 1'b1; rsp_ready = 1'b0;
    s0 = start_cnt;
    send_cmd(3'b001, 8'h10, 8'h20);
    wait_rsp(lat, rhi);
    chk("tmo_wait_cycles", 32'(lat - 1), 32'(TMO));
    chk("tmo_status", 32'(rsp_status), 32'd2);
    chk("tmo_result", 32'(rsp_result), 32'd0);
    chk("tmo_starts", 32'(start_cnt - s0), 32'd1);
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    @(negedge clk);
    chk("tmo_late_status", 32'(rsp_status), 32'd2);
    chk("tmo_late_result", 32'(rsp_result), 32'd0);
    chk("tmo_still_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo_done_cnt", 32'(done_cnt), 32'(exp_cnt));
    alu_hang = 1'b0;

    // Backpressure: response held stable while rsp_ready is low
    rsp_ready = 1'b0;
    send_cmd(3'b001, 8'h03, 8'h04);
    wait_rsp(lat, rhi);
    rhi = 0;
    for (int k = 0; k < 10; k++) begin
      if (!rsp_valid || rsp_result !== 16'h0007 || rsp_status !== 2'b00 || cmd_ready) rhi++;
      @(negedge clk);
    end
    chk("bp_hold_stable", 32'(rhi), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);
    chk("bp_done_cnt", 32'(done_cnt), 32'(exp_cnt));

    // Reset during WAIT discards the command and clears the counter
    alu_hang = 1'b1;
    send_cmd(3'b001, 8'h09, 8'h09);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_alu_start", 32'(alu_start), 32'd0);
    chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_reset_done_cnt", 32'(done_cnt), 32'd0);
    reset_n = 1'b1; alu_hang = 1'b0;
    rhi = 0;
    for (int k = 0; k < TMO + 4; k++) begin
      if (rsp_valid) rhi++;
      @(negedge clk);
    end
    chk("aborted_no_rsp", 32'(rhi), 32'd0);
    send_cmd(3'b001, 8'h01, 8'h01);
    wait_rsp(lat, rhi);
    chk("post_reset_result", 32'(rsp_result), 32'h0002);
    chk("post_reset_status", 32'(rsp_status), 32'd0);
    @(negedge clk);
    chk("post_reset_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
